// File: rtl/cpr_pkg.sv
// -----------------------------------------------------------------------------
// cpr_pkg
// Definitions shared by the compress-unit arbiter and, later, the packer.
//   - Beat geometry: WORDS words of WORD_W bits each, with a TAG_W-bit tag per word.
//   - Tag encodings and tag_bytes(), which maps one tag to its byte count.
//   - Arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package cpr_pkg;

    localparam int TAG_W  = 2;
    localparam int WORDS  = 8;
    localparam int WORD_W = 32;
    localparam int BEAT_W = WORDS * WORD_W;   // 256
    localparam int TAGS_W = WORDS * TAG_W;    // 16
    localparam int LEN_W  = 6;                // holds 0..32

    typedef enum logic [TAG_W-1:0] {
        TAG_ZERO = 2'b00,
        TAG_B1   = 2'b01,
        TAG_B2   = 2'b10,
        TAG_B4   = 2'b11
    } tag_e;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Compressed byte count of one word, taken from its tag.
    function automatic logic [2:0] tag_bytes(input logic [TAG_W-1:0] tag);
        logic [2:0] b;
        b = 3'd0;
        case (tag_e'(tag))
            TAG_ZERO: b = 3'd0;
            TAG_B1:   b = 3'd1;
            TAG_B2:   b = 3'd2;
            TAG_B4:   b = 3'd4;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cpr_len_calc.sv
// -----------------------------------------------------------------------------
// cpr_len_calc
// Combinational compressed-length calculator. It sums the per-word byte counts
// of all WORDS tags.
//   i_tags : TAGS_W  packed tags, word j in bits [2j+1:2j]
//   o_len  : LEN_W   total bytes, 0..32 (the width cannot overflow)
// -----------------------------------------------------------------------------
module cpr_len_calc
    import cpr_pkg::*;
(
    input  logic [TAGS_W-1:0] i_tags,
    output logic [LEN_W-1:0]  o_len
);

    always_comb begin
        o_len = '0;
        for (int j = 0; j < WORDS; j++) begin
            o_len = o_len + LEN_W'(tag_bytes(i_tags[j*TAG_W +: TAG_W]));
        end
    end

endmodule

// File: rtl/cpr_unit_arbiter.sv
// -----------------------------------------------------------------------------
// cpr_unit_arbiter
// Round-robin arbiter that shares one 8-word compress unit among NUM_REQ
// requesters. It issues at most one beat per cycle. It tracks the owner of each
// beat through the unit's fixed pipeline and returns the compressed beat, its
// tags and its byte length to that owner. Locked packets hold the grant on one
// requester until that requester's last beat.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/lock/last   per-requester beat valid, locked-packet flag, last beat
//   req_data              per-requester beat, requester i at [256*i +: 256]
//   req_ready             one-hot grant, combinational
//   cu_wrtEn, cu_dataIn   registered issue into the compress unit
//   cu_dataOut, cu_tagOut compress unit result, valid CU_LATENCY edges after it samples
//   rsp_valid             one-hot response strobe, registered
//   rsp_data/tag/len      response payload shared by all requesters
//   busy                  locked, or at least one beat still in flight
//
// Timing: a beat accepted at edge k has its response registered at edge
// k+CU_LATENCY+1. The unit cannot stall, so responses are never back-pressured.
// -----------------------------------------------------------------------------
module cpr_unit_arbiter
    import cpr_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CU_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BEAT_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cu_wrtEn,
    output logic [BEAT_W-1:0]         cu_dataIn,
    input  logic [BEAT_W-1:0]         cu_dataOut,
    input  logic [TAGS_W-1:0]         cu_tagOut,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [BEAT_W-1:0]         rsp_data,
    output logic [TAGS_W-1:0]         rsp_tag,
    output logic [LEN_W-1:0]          rsp_len,
    output logic                      busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    // The ID pipeline has stages 0..STAGES, which is CU_LATENCY+1 entries.
    // Stage 0 is loaded on the accept edge. Stage STAGES lines up with the
    // unit's output.
    localparam int STAGES = CU_LATENCY;

    arb_state_e                     r_state;
    logic [IDX_W-1:0]               r_ptr;
    logic [IDX_W-1:0]               r_owner;
    logic [STAGES:0]                r_vld_pipe;
    logic [STAGES:0][IDX_W-1:0]     r_idx_pipe;

    logic [NUM_REQ-1:0][BEAT_W-1:0] w_req_beats;
    logic                           w_grant_vld;
    logic [IDX_W-1:0]               w_grant_idx;
    logic [IDX_W-1:0]               w_cand;
    logic [NUM_REQ-1:0]             w_rsp_oh;
    logic [LEN_W-1:0]               w_len;

    // The flat request bus viewed as one beat per requester.
    assign w_req_beats = req_data;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (r_state == ST_LOCKED) begin
            // The owner keeps the unit even while it is idle.
            w_grant_vld = req_valid[r_owner];
            w_grant_idx = r_owner;
        end else begin
            // Walk from the farthest candidate back toward ptr+1. The last
            // hit written is then the first valid requester after ptr.
            for (int off = NUM_REQ; off >= 1; off--) begin
                w_cand = IDX_W'((int'(r_ptr) + off) % NUM_REQ);
                if (req_valid[w_cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_vld) req_ready[w_grant_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Arbitration FSM and round-robin pointer. Both advance only on an
    // accepted beat.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ARB;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_owner <= '0;
        end else if (w_grant_vld) begin
            r_ptr <= w_grant_idx;
            case (r_state)
                ST_ARB: begin
                    // lock with last is a one-beat packet and never locks.
                    if (req_lock[w_grant_idx] && !req_last[w_grant_idx]) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_grant_idx;
                    end
                end
                ST_LOCKED: begin
                    if (req_last[w_grant_idx]) r_state <= ST_ARB;
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue register and owner-ID pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cu_wrtEn   <= 1'b0;
            cu_dataIn  <= '0;
            r_vld_pipe <= '0;
            r_idx_pipe <= '0;
        end else begin
            cu_wrtEn <= w_grant_vld;
            if (w_grant_vld) cu_dataIn <= w_req_beats[w_grant_idx];
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_grant_vld};
            r_idx_pipe <= {r_idx_pipe[STAGES-1:0], w_grant_idx};
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    cpr_len_calc u_len (
        .i_tags (cu_tagOut),
        .o_len  (w_len)
    );

    always_comb begin
        w_rsp_oh = '0;
        if (r_vld_pipe[STAGES]) w_rsp_oh[r_idx_pipe[STAGES]] = 1'b1;
    end

    // The payload holds between responses. Only rsp_valid marks a new beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_len   <= '0;
        end else begin
            rsp_valid <= w_rsp_oh;
            if (r_vld_pipe[STAGES]) begin
                rsp_data <= cu_dataOut;
                rsp_tag  <= cu_tagOut;
                rsp_len  <= w_len;
            end
        end
    end

    assign busy = (r_state == ST_LOCKED) || (|r_vld_pipe);

endmodule

// File: tb/tb_cpr_unit_arbiter.sv
// Bench for cpr_unit_arbiter. Two instances share the request inputs: one
// built with CU_LATENCY=1 and one with CU_LATENCY=3. Each has its own
// compress-unit model, which outputs the inverted beat as data and the beat's
// low 16 bits as tags. Each also has its own scoreboard queue that a
// negedge monitor checks for payload, length and exact arrival edge.
module tb_cpr_unit_arbiter;
    import cpr_pkg::*;

    localparam int N  = 4;
    localparam int LA = 1;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]        req_valid, req_lock, req_last;
    logic [N*BEAT_W-1:0] req_data;

    logic [N-1:0]  a_ready, a_rsp_valid, b_ready, b_rsp_valid;
    logic          a_wr, b_wr, a_busy, b_busy;
    logic [255:0]  a_din, a_dout, a_rsp_data, b_din, b_dout, b_rsp_data;
    logic [15:0]   a_tout, a_rsp_tag, b_tout, b_rsp_tag;
    logic [5:0]    a_rsp_len, b_rsp_len;

    cpr_unit_arbiter #(.NUM_REQ(N), .CU_LATENCY(LA)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_last(req_last), .req_ready(a_ready),
        .cu_wrtEn(a_wr), .cu_dataIn(a_din), .cu_dataOut(a_dout), .cu_tagOut(a_tout),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_tag(a_rsp_tag),
        .rsp_len(a_rsp_len), .busy(a_busy));

    cpr_unit_arbiter #(.NUM_REQ(N), .CU_LATENCY(LB)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_last(req_last), .req_ready(b_ready),
        .cu_wrtEn(b_wr), .cu_dataIn(b_din), .cu_dataOut(b_dout), .cu_tagOut(b_tout),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_tag(b_rsp_tag),
        .rsp_len(b_rsp_len), .busy(b_busy));

    // Compress unit models: sample at every edge, output after L edges.
    logic [271:0] a_cu [LA];
    logic [271:0] b_cu [LB];
    always @(posedge clk) begin
        a_cu[0] <= {~a_din, a_din[15:0]};
        b_cu[0] <= {~b_din, b_din[15:0]};
        for (int s = 1; s < LB; s++) b_cu[s] <= b_cu[s-1];
    end
    assign a_dout = a_cu[LA-1][271:16];
    assign a_tout = a_cu[LA-1][15:0];
    assign b_dout = b_cu[LB-1][271:16];
    assign b_tout = b_cu[LB-1][15:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] oh;
        logic [255:0] data;
        logic [15:0]  tag;
        logic [5:0]   len;
        int           cyc;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    function automatic logic [5:0] ref_len(input logic [15:0] t);
        int s;
        s = 0;
        for (int j = 0; j < 8; j++) begin
            case (t[2*j +: 2])
                2'b01:   s += 1;
                2'b10:   s += 2;
                2'b11:   s += 4;
                default: s += 0;
            endcase
        end
        return s[5:0];
    endfunction

    // Reference arbiter state
    int m_ptr;
    int m_locked;
    int m_owner;

    function automatic logic [N-1:0] mdl_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_locked != 0) begin
            if (req_valid[m_owner]) g[m_owner] = 1'b1;
        end else begin
            for (int off = 1; off <= N; off++) begin
                int i;
                i = (m_ptr + off) % N;
                if (req_valid[i]) begin
                    g[i] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    function automatic void mdl_reset();
        m_ptr    = N - 1;
        m_locked = 0;
        m_owner  = 0;
    endfunction

    task automatic rand_data();
        for (int r = 0; r < N; r++)
            for (int w = 0; w < 8; w++)
                req_data[r*256 + w*32 +: 32] = $urandom;
    endtask

    task automatic set_req(input logic [N-1:0] v, input logic [N-1:0] lk, input logic [N-1:0] ls);
        req_valid = v;
        req_lock  = lk;
        req_last  = ls;
    endtask

    // Check the grant against the model, record the expected response, then
    // advance one edge. A non-negative exp_len overrides the computed length.
    task automatic step(input int exp_len = -1);
        logic [N-1:0] g;
        int gi;
        exp_t e;
        #1;
        g = mdl_grant();
        chk("a_req_ready", a_ready, g);
        chk("b_req_ready", b_ready, g);
        if (g != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (g[i]) gi = i;
            e.oh   = g;
            e.data = ~req_data[gi*256 +: 256];
            e.tag  = req_data[gi*256 +: 16];
            e.len  = (exp_len >= 0) ? exp_len[5:0] : ref_len(e.tag);
            e.cyc  = cyc + LA + 2;
            qa.push_back(e);
            e.cyc  = cyc + LB + 2;
            qb.push_back(e);
            m_ptr = gi;
            if (m_locked == 0 && req_lock[gi] && !req_last[gi]) begin
                m_locked = 1;
                m_owner  = gi;
            end else if (m_locked != 0 && req_last[gi]) begin
                m_locked = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_req('0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Response monitors
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && a_rsp_valid !== '0) begin
            if (qa.size() == 0) chk("a_rsp_unexpected", a_rsp_valid, '0);
            else begin
                e = qa.pop_front();
                chk("a_rsp_valid", a_rsp_valid, e.oh);
                chk("a_rsp_data",  a_rsp_data,  e.data);
                chk("a_rsp_tag",   a_rsp_tag,   e.tag);
                chk("a_rsp_len",   a_rsp_len,   e.len);
                chk("a_rsp_edge",  cyc,         e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && b_rsp_valid !== '0) begin
            if (qb.size() == 0) chk("b_rsp_unexpected", b_rsp_valid, '0);
            else begin
                e = qb.pop_front();
                chk("b_rsp_valid", b_rsp_valid, e.oh);
                chk("b_rsp_data",  b_rsp_data,  e.data);
                chk("b_rsp_tag",   b_rsp_tag,   e.tag);
                chk("b_rsp_len",   b_rsp_len,   e.len);
                chk("b_rsp_edge",  cyc,         e.cyc);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_a_wrtEn"}, a_wr, '0);
        chk({tag, "_a_dataIn"}, a_din, '0);
        chk({tag, "_a_rsp_valid"}, a_rsp_valid, '0);
        chk({tag, "_a_rsp_data"}, a_rsp_data, '0);
        chk({tag, "_a_rsp_tag"}, a_rsp_tag, '0);
        chk({tag, "_a_rsp_len"}, a_rsp_len, '0);
        chk({tag, "_a_busy"}, a_busy, '0);
        chk({tag, "_b_wrtEn"}, b_wr, '0);
        chk({tag, "_b_rsp_valid"}, b_rsp_valid, '0);
        chk({tag, "_b_busy"}, b_busy, '0);
    endtask

    typedef struct {
        int           rq;
        logic [15:0]  tag;
        logic [N-1:0] ready;
        int           len;
    } vec_t;
    vec_t tbl[4];

    initial begin
        tbl[0] = '{0, 16'b0100011011011011, 4'b0001, 15};
        tbl[1] = '{1, 16'h0000,             4'b0010, 0};
        tbl[2] = '{3, 16'hFFFF,             4'b1000, 32};
        tbl[3] = '{2, 16'b1000000000001011, 4'b0100, 8};

        reset    = 1'b0;
        req_data = '0;
        set_req('0, '0, '0);
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset_a_ready", a_ready, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single beats with known tags
        for (int i = 0; i < 4; i++) begin
            rand_data();
            req_data[tbl[i].rq*256 +: 16] = tbl[i].tag;
            set_req(N'(1) << tbl[i].rq, '0, '0);
            #1;
            chk("tbl_ready", a_ready, tbl[i].ready);
            step(tbl[i].len);
            idle(1);
        end
        idle(4);

        // All requesters valid. The last grant was 2, so the rotation starts at 3.
        set_req('1, '0, '0);
        for (int c = 0; c < 8; c++) begin
            rand_data();
            #1;
            chk("rr_order", a_ready, N'(1) << ((3 + c) % N));
            step();
        end
        idle(6);

        // A 3-beat locked packet from requester 2 against a busy requester 1
        rand_data();
        set_req(4'b0100, 4'b0100, 4'b0000);
        #1; chk("lock_b1_ready", a_ready, 4'b0100);
        step();
        set_req(4'b0010, 4'b0000, 4'b0000);         // owner idle
        #1; chk("lock_idle_ready", a_ready, 4'b0000);
        chk("lock_busy", a_busy, 1'b1);
        step();
        rand_data();
        set_req(4'b0110, 4'b0100, 4'b0000);
        #1; chk("lock_b2_ready", a_ready, 4'b0100);
        step();
        rand_data();
        set_req(4'b0110, 4'b0100, 4'b0100);
        #1; chk("lock_b3_ready", a_ready, 4'b0100);
        step();
        rand_data();
        set_req(4'b0110, 4'b0000, 4'b0000);
        #1; chk("after_lock_ready", a_ready, 4'b0010);
        step();
        // One-beat packet (lock and last together) must not lock
        rand_data();
        set_req(4'b1000, 4'b1000, 4'b1000);
        step();
        rand_data();
        set_req(4'b1001, 4'b0000, 4'b0000);
        #1; chk("one_beat_no_lock", a_ready, 4'b0001);
        step();
        idle(8);
        chk("drain_a_busy", a_busy, 1'b0);
        chk("drain_b_busy", b_busy, 1'b0);
        chk("drain_qa", qa.size(), 0);
        chk("drain_qb", qb.size(), 0);

        // Reset with two beats in flight while LOCKED
        rand_data();
        set_req(4'b0100, 4'b0100, 4'b0000);
        step();
        rand_data();
        set_req(4'b0100, 4'b0100, 4'b0000);
        step();
        chk("pre_reset_busy", b_busy, 1'b1);
        set_req('0, '0, '0);
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        qa.delete();
        qb.delete();
        mdl_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(8);
        rand_data();
        set_req('1, '0, '0);
        #1;
        chk("rst_first_a", a_ready, 4'b0001);
        chk("rst_first_b", b_ready, 4'b0001);
        for (int c = 0; c < 4; c++) begin
            rand_data();
            step();
        end
        idle(8);
        chk("end_qa", qa.size(), 0);
        chk("end_qb", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpr_unit_arbiter.md
# cpr_unit_arbiter

Round-robin arbiter that shares one eight-word compress unit (256-bit data in; 256-bit compressed data plus 16-bit tag out) among NUM_REQ requesters. It issues at most one 8-word beat per cycle into the unit and tracks the owner of each beat through the unit's fixed pipeline. It returns each compressed beat, its tag and its compressed byte length to the requester that issued it. It supports locked multi-beat packets so one requester's stream is never interleaved with another's.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CU_LATENCY, 1, edges from compress unit input sample to valid compress unit output (1..4)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  256*NUM_REQ  per-requester 8x32-bit words; requester i uses bits [256*i +: 256]
- req_lock  in  NUM_REQ  beat belongs to a locked packet
- req_last  in  NUM_REQ  final beat of a locked packet
- req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid and state
- cu_wrtEn  out  1  write enable to the compress unit, registered
- cu_dataIn  out  256  data to the compress unit, registered
- cu_dataOut  in  256  compressed words from the unit
- cu_tagOut  in  16  2-bit tag per word; word j uses bits [2j+1:2j]
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  256  compressed data, shared by all requesters
- rsp_tag  out  16  tags, shared
- rsp_len  out  6  compressed length in bytes (0..32)
- busy  out  1  state is LOCKED or at least one beat is in flight

## Operation

- Handshake: a beat from requester i is accepted when req_valid[i] && req_ready[i] at a rising edge. At most one bit of req_ready is high in any cycle.
- Arbitration (state ARB):
  - Grant the first valid requester scanning from ptr+1 upward, wrapping modulo NUM_REQ.
  - ptr holds the last granted index and resets to NUM_REQ-1, so requester 0 wins first.
  - ptr updates only on an accepted beat.
- FSM has two states, ARB and LOCKED:
  - ARB -> LOCKED on an accepted beat with req_lock=1 and req_last=0. The owner index is latched.
  - In LOCKED, only the owner can be granted. Other requesters see req_ready=0 even when the owner is idle.
  - LOCKED -> ARB on an accepted owner beat with req_last=1.
  - A beat with req_lock=1 and req_last=1 accepted in ARB is a one-beat packet; the FSM stays in ARB.
  - req_lock=0 never enters LOCKED.
- Issue: each accepted beat is registered into cu_dataIn, with cu_wrtEn=1 for exactly the next cycle. Otherwise cu_wrtEn=0 and cu_dataIn holds its last value.
- Owner tracking:
  - An ID pipeline of depth CU_LATENCY+1 carries {valid, index} for each beat.
  - The compress unit has no stall, so responses are never back-pressured. Requesters must accept rsp_valid unconditionally.
- Length:
  - Per-word byte count from its tag: 00->0, 01->1, 10->2, 11->4.
  - rsp_len is the unsigned sum over the 8 tags, computed in 6 bits with no overflow (maximum 32).

## Timing

- Accept at edge k:
  - cu_wrtEn is high in the cycle after edge k.
  - The unit samples at edge k+1.
  - cu_dataOut and cu_tagOut are valid after edge k+CU_LATENCY.
  - rsp_* are registered at edge k+CU_LATENCY+1.
- Total latency is CU_LATENCY+2 edges, with a throughput of 1 beat per cycle.
- Responses return in issue order. Back-to-back accepts produce back-to-back rsp_valid.
- Reset (asynchronous, active-low) forces:
  - cu_wrtEn=0, cu_dataIn=0
  - rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_len=0
  - busy=0, state=ARB, ptr=NUM_REQ-1, ID pipeline cleared
- Reset asserted mid-operation drops in-flight beats: no rsp_valid is produced for them and any lock is released.
- If an owner deasserts req_valid while LOCKED, the arbiter waits indefinitely. There is no timeout.
- All req_valid low gives req_ready=0 and leaves ptr unchanged.

## Structure

- Shared package cpr_pkg holds:
  - TAG_W=2, WORDS=8, WORD_W=32
  - tag encodings TAG_ZERO=00, TAG_B1=01, TAG_B2=10, TAG_B4=11
  - function tag_bytes(tag) returning the byte count
- Sub-module cpr_len_calc: combinational 16-bit tag -> 6-bit byte count, reused later by the packer.
- The ID pipeline and round-robin logic stay in the top module.

## Test plan

- Single requester 0 issues a beat with the compress unit modelled as returning tag 16'b0100011011011011 -> rsp_valid=4'b0001 at edge k+CU_LATENCY+2, rsp_len=15.
- Requesters 0..3 all valid every cycle -> grants go 0,1,2,3,0,... one per cycle; each response lands on the matching rsp_valid bit, in order.
- Requester 2 sends a 3-beat locked packet (req_lock=1; req_last=1 on beat 3) while requester 1 is continuously valid -> req_ready[1]=0 until beat 3 is accepted, then requester 1 is granted next.
- Tag 16'h0000 gives rsp_len=0; tag 16'hFFFF gives rsp_len=32; tag 16'b1000000000001011 gives rsp_len=8.
- Reset asserted with 2 beats in flight and the FSM in LOCKED -> all outputs zero immediately, no rsp_valid after release, and requester 0 is granted first.
- CU_LATENCY=3 build with back-to-back beats -> latency is 5 edges and there are no gaps between responses.
